hpu_prf_freelist: RTL

- Allocates and recycles physical scalar register indices for the rename stage.
- Tracks a per-physical-register ready bit. The bit is cleared on allocation and set by the four PRF write ports (alu0, alu1, mdu, lsu).
- Sits between rename, the retire/commit unit and the PRF write buses. Guarantees that no physical register is handed out twice while live.
- Restores the committed free-list state on pipeline flush.

---
 rtl/hpu_prf_freelist.sv | 116 +++++++++++
 1 files changed

// File: rtl/hpu_prf_freelist.sv
// Physical register free list with per-register ready bits for rename.
// Speculative head rolls back to the committed head on flush; writeback bypasses into ready queries.
module hpu_prf_freelist #(
  parameter  int unsigned PHY_NUM  = 64,
  parameter  int unsigned ARCH_NUM = 32,
  localparam int unsigned IW       = $clog2(PHY_NUM),
  localparam int unsigned FL_DEPTH = PHY_NUM - ARCH_NUM,
  localparam int unsigned AW       = $clog2(FL_DEPTH),
  localparam int unsigned PW       = AW + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        rn_fl__alloc_req_i,
  output logic              fl_rn__alloc_gnt_o,
  output logic [2*IW-1:0]   fl_rn__alloc_index_o,
  input  logic [1:0]        rcu_fl__release_en_i,
  input  logic [2*IW-1:0]   rcu_fl__release_index_i,
  input  logic [3:0]        wb_fl__wr_en_i,
  input  logic [4*IW-1:0]   wb_fl__wr_index_i,
  input  logic [4*IW-1:0]   rn_fl__query_index_i,
  output logic [3:0]        fl_rn__query_ready_o,
  input  logic              flush_i,
  output logic [PW-1:0]     fl__free_cnt_o,
  output logic              fl__overflow_o
);

  localparam int unsigned CW = PW + 1;

  logic [IW-1:0]      fl_q [FL_DEPTH];
  logic [IW-1:0]      fl_d [FL_DEPTH];
  logic [PW-1:0]      spec_head_q, spec_head_d;
  logic [PW-1:0]      cmt_head_q, cmt_head_d;
  logic [PW-1:0]      tail_q, tail_d;
  logic [PW-1:0]      free_cnt_q, free_cnt_d;
  logic [PHY_NUM-1:0] ready_q, ready_d;
  logic               overflow_q, overflow_d;

  logic [1:0]         n_alloc, n_take, n_rel;
  logic               alloc_gnt;
  logic [PW-1:0]      head1, rel_ptr1;
  logic [IW-1:0]      idx0, idx1, q_idx;
  logic [CW-1:0]      cnt_ext;
  logic [3:0]         query_ready;

  // Grant, pointer advance, release write, ready tracking and query bypass
  always_comb begin
    n_alloc     = 2'(rn_fl__alloc_req_i[0]) + 2'(rn_fl__alloc_req_i[1]);
    n_rel       = 2'(rcu_fl__release_en_i[0]) + 2'(rcu_fl__release_en_i[1]);
    alloc_gnt   = (n_alloc != 2'd0) && (free_cnt_q >= PW'(n_alloc)) && !flush_i && !rst_i;
    n_take      = alloc_gnt ? n_alloc : 2'd0;
    head1       = spec_head_q + PW'(1);
    idx0        = fl_q[spec_head_q[AW-1:0]];
    idx1        = fl_q[head1[AW-1:0]];
    rel_ptr1    = tail_q + PW'(rcu_fl__release_en_i[0]);

    fl_d = fl_q;
    if (rcu_fl__release_en_i[0]) fl_d[tail_q[AW-1:0]]   = rcu_fl__release_index_i[IW-1:0];
    if (rcu_fl__release_en_i[1]) fl_d[rel_ptr1[AW-1:0]] = rcu_fl__release_index_i[2*IW-1:IW];

    tail_d      = tail_q + PW'(n_rel);
    cmt_head_d  = cmt_head_q + PW'(n_rel);
    spec_head_d = flush_i ? cmt_head_d : spec_head_q + PW'(n_take);
    free_cnt_d  = tail_d - spec_head_d;

    // Widened count so a release past full is detectable before wrapping
    cnt_ext     = CW'(free_cnt_q) + CW'(n_rel) - CW'(n_take);
    overflow_d  = overflow_q | (cnt_ext > CW'(FL_DEPTH));

    ready_d = ready_q;
    if (alloc_gnt) begin
      ready_d[idx0] = 1'b0;
      if (n_alloc == 2'd2) ready_d[idx1] = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      if (wb_fl__wr_en_i[i]) ready_d[wb_fl__wr_index_i[i*IW +: IW]] = 1'b1;
    end
    if (flush_i) ready_d = '1;

    query_ready = '0;
    q_idx       = '0;
    for (int j = 0; j < 4; j++) begin
      q_idx          = rn_fl__query_index_i[j*IW +: IW];
      query_ready[j] = ready_q[q_idx];
      for (int i = 0; i < 4; i++) begin
        if (wb_fl__wr_en_i[i] && (wb_fl__wr_index_i[i*IW +: IW] == q_idx)) query_ready[j] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < FL_DEPTH; k++) fl_q[k] <= IW'(ARCH_NUM + k);
      spec_head_q <= '0;
      cmt_head_q  <= '0;
      tail_q      <= PW'(FL_DEPTH);
      free_cnt_q  <= PW'(FL_DEPTH);
      ready_q     <= '1;
      overflow_q  <= 1'b0;
    end else begin
      fl_q        <= fl_d;
      spec_head_q <= spec_head_d;
      cmt_head_q  <= cmt_head_d;
      tail_q      <= tail_d;
      free_cnt_q  <= free_cnt_d;
      ready_q     <= ready_d;
      overflow_q  <= overflow_d;
    end
  end

  assign fl_rn__alloc_gnt_o   = alloc_gnt;
  assign fl_rn__alloc_index_o = {idx1, idx0};
  assign fl_rn__query_ready_o = query_ready;
  assign fl__free_cnt_o       = free_cnt_q;
  assign fl__overflow_o       = overflow_q;

endmodule
